// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory front end: memory geometry,
// FSM state codes and the encoding of who currently owns the memory port.
package dmem_pkg;

  localparam int DEPTH        = 128;
  localparam int DATA_W       = 64;
  localparam int STARVE_LIMIT = 8;

  // FSM state codes
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // Memory port owner for the current cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG,
    OWN_CLR
  } owner_e;

endpackage

// File: rtl/dmem_clear_seq.sv
// Clear sequencer: walks a word index from 0 to DEPTH-1 while enabled and
// flags the cycle that writes the last word.
module dmem_clear_seq #(
  parameter int DEPTH = 128,
  localparam int CW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] clrCnt,
  output logic          done
);

  assign done = en && (clrCnt == CW'(DEPTH - 1));

  // Word index: restarts at 0 on reset and after the final word
  always_ff @(posedge clk) begin
    if (!reset) begin
      clrCnt <= '0;
    end else if (done) begin
      clrCnt <= '0;
    end else if (en) begin
      clrCnt <= clrCnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory front end: zero-fills the memory after reset, then shares the
// single memory port between the MEM stage (priority) and a debug/loader
// port using a req/gnt handshake. Addresses at or beyond DEPTH never write
// and read back as zero.
//
// Build option: DMEM_ARB_STARVE_GUARD_EN adds a starvation guard that forces
// a debug grant (stalling the CPU) after STARVE_LIMIT consecutive denials.
module dmem_arbiter #(
  parameter int DEPTH        = dmem_pkg::DEPTH,
`ifdef DMEM_ARB_STARVE_GUARD_EN
  parameter int STARVE_LIMIT = dmem_pkg::STARVE_LIMIT,
`endif
  parameter int DATA_W       = dmem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [63:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic [63:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_busy
);

  import dmem_pkg::*;

  localparam int CW = $clog2(DEPTH);

  logic [0:0]        state;
  owner_e            owner;
  logic [CW-1:0]     clrCnt;
  logic              clrDone;
  logic              cpuAcc;
  logic              forceDbg;
  logic              dbgRd;
  logic              dbgValid_p1;
  logic [DATA_W-1:0] dbgRdata_p1;

  function automatic logic addrOk(input logic [63:0] addr);
    return addr < 64'(DEPTH);
  endfunction

  assign cpuAcc = cpu_read | cpu_write;

  dmem_clear_seq #(
    .DEPTH (DEPTH)
  ) uClearSeq (
    .clk    (clk),
    .reset  (reset),
    .en     (reset && (state == CLEAR)),
    .clrCnt (clrCnt),
    .done   (clrDone)
  );

  // Two-state FSM: clear after every reset, then run
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
    end else if ((state == CLEAR) && clrDone) begin
      state <= RUN;
    end
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starveCnt;

  assign forceDbg = (state == RUN) && dbg_req && (starveCnt == SW'(STARVE_LIMIT));

  // Consecutive-denial counter; any grant or a dropped request clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if ((state == RUN) && dbg_req && !dbg_gnt) begin
      starveCnt <= starveCnt + 1'b1;
    end else begin
      starveCnt <= '0;
    end
  end
`else
  assign forceDbg = 1'b0;
`endif

  // Owner selection: clear sequencer, forced debug, CPU, then debug
  always_comb begin
    owner = OWN_NONE;
    if (!reset) begin
      owner = OWN_NONE;
    end else if (state == CLEAR) begin
      owner = OWN_CLR;
    end else if (forceDbg) begin
      owner = OWN_DBG;
    end else if (cpuAcc) begin
      owner = OWN_CPU;
    end else if (dbg_req) begin
      owner = OWN_DBG;
    end
  end

  // Memory port mux; out-of-range addresses never write and read as zero
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_rdata = '0;
    case (owner)
      OWN_CLR: begin
        mem_addr  = 64'(clrCnt);
        mem_write = 1'b1;
      end
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = cpu_read;
        mem_write = cpu_write & addrOk(cpu_addr);
        cpu_rdata = addrOk(cpu_addr) ? mem_rdata : '0;
      end
      OWN_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_read  = ~dbg_we;
        mem_write = dbg_we & addrOk(dbg_addr);
      end
      default: ;
    endcase
  end

  assign dbg_gnt   = (owner == OWN_DBG);
  assign dbgRd     = dbg_gnt & ~dbg_we;
  assign cpu_stall = !reset || (state == CLEAR) || forceDbg;
  assign init_busy = !reset || (state == CLEAR);

  // Debug read return stage: data and valid one cycle after the grant
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbgValid_p1 <= 1'b0;
      dbgRdata_p1 <= '0;
    end else begin
      dbgValid_p1 <= dbgRd;
      if (dbgRd) begin
        dbgRdata_p1 <= addrOk(dbg_addr) ? mem_rdata : '0;
      end
    end
  end

  assign dbg_valid = dbgValid_p1;
  assign dbg_rdata = dbgRdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory sits on the mem_* port, and a
// reference model (word array, pending debug request, denial count) predicts
// every output cycle by cycle. Build with DMEM_ARB_STARVE_GUARD_EN to
// exercise the starvation guard.
module tb_dmem_arbiter;

  localparam int DEPTH = 128;
  localparam int LIMIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cpu_stall;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_valid;
  logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        init_busy;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory; scrambled while reset is low so the clear
  // sequence has something to erase. Out-of-range reads return garbage.
  logic [63:0] mem [DEPTH];
  int          badWrites = 0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'hC0FFEE00_00000000 | 64'(i);
    end else if (mem_write) begin
      if (mem_addr < 64'(DEPTH)) mem[mem_addr[6:0]] <= mem_wdata;
      else badWrites <= badWrites + 1;
    end
  end

  assign mem_rdata = (mem_addr < 64'(DEPTH)) ? mem[mem_addr[6:0]] : 64'hA5A5A5A5_5A5A5A5A;

  int nCmp = 0;
  int nFail = 0;

  // Reference model state
  logic [63:0] refMem [DEPTH];
  bit          pend, pWe;
  logic [63:0] pAddr, pData;
  int          denied;
  bit          expValid;
  logic [63:0] expRdata;

  // Values observed in the last modelled cycle, for directed checks
  logic        obsGnt, obsStall, obsMemWrite, obsValid;
  logic [63:0] obsCpuRdata, obsDbgRdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic dbgStart(input bit we, input logic [63:0] a, input logic [63:0] d);
    pend = 1'b1; pWe = we; pAddr = a; pData = d;
  endtask

  // One RUN-mode cycle: op 0 = idle, 1 = cpu read, 2 = cpu write
  task automatic runCycle(input int op, input logic [63:0] a, input logic [63:0] d);
    bit          inR, dIn, forced, cpuOwn, gnt, eWr, eRd;
    logic [63:0] eCpu, eAddr;
    @(negedge clk);
    obsValid    = dbg_valid;
    obsDbgRdata = dbg_rdata;
    chk1("dbg_valid", dbg_valid, expValid);
    chk("dbg_rdata", dbg_rdata, expRdata);
    cpu_read  = (op == 1);
    cpu_write = (op == 2);
    cpu_addr  = a;
    cpu_wdata = d;
    dbg_req   = pend;
    dbg_we    = pWe;
    dbg_addr  = pAddr;
    dbg_wdata = pData;
    #1;
    inR    = a < 64'(DEPTH);
    dIn    = pAddr < 64'(DEPTH);
    forced = GUARD && pend && (denied == LIMIT);
    cpuOwn = (op != 0) && !forced;
    gnt    = pend && (forced || op == 0);
    eCpu   = (cpuOwn && inR) ? refMem[a[6:0]] : 64'd0;
    eWr    = (cpuOwn && op == 2 && inR) || (gnt && pWe && dIn);
    eRd    = (cpuOwn && op == 1) || (gnt && !pWe);
    eAddr  = cpuOwn ? a : (gnt ? pAddr : 64'd0);
    chk1("cpu_stall", cpu_stall, forced);
    chk1("dbg_gnt", dbg_gnt, gnt);
    chk1("mem_write", mem_write, eWr);
    chk1("mem_read", mem_read, eRd);
    chk("mem_addr", mem_addr, eAddr);
    chk("cpu_rdata", cpu_rdata, eCpu);
    chk1("init_busy_run", init_busy, 1'b0);
    obsGnt = dbg_gnt; obsStall = cpu_stall; obsMemWrite = mem_write; obsCpuRdata = cpu_rdata;
    if (gnt && !pWe) begin
      expValid = 1'b1;
      expRdata = dIn ? refMem[pAddr[6:0]] : 64'd0;
    end else begin
      expValid = 1'b0;
    end
    if (cpuOwn && op == 2 && inR) refMem[a[6:0]] = d;
    if (gnt && pWe && dIn) refMem[pAddr[6:0]] = pData;
    denied = (pend && !gnt) ? denied + 1 : 0;
    if (gnt) pend = 1'b0;
  endtask

  // Release reset and follow the full clear sequence word by word
  task automatic doClear();
    @(negedge clk);
    idleInputs();
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk1("clr_mem_write", mem_write, 1'b1);
      chk("clr_mem_addr", mem_addr, 64'(i));
      chk("clr_mem_wdata", mem_wdata, 64'd0);
      chk1("clr_init_busy", init_busy, 1'b1);
      chk1("clr_cpu_stall", cpu_stall, 1'b1);
      chk1("clr_dbg_gnt", dbg_gnt, 1'b0);
      @(negedge clk);
    end
    #1;
    chk1("post_clr_init_busy", init_busy, 1'b0);
    chk1("post_clr_cpu_stall", cpu_stall, 1'b0);
    for (int i = 0; i < DEPTH; i++) refMem[i] = 64'd0;
    expValid = 1'b0; expRdata = 64'd0; pend = 1'b0; denied = 0;
  endtask

  task automatic chkMemImage(input string tag);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk(tag, mem[i], refMem[i]);
    chk("bad_writes", 64'(badWrites), 64'd0);
  endtask

  function automatic logic [63:0] randAddr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return {$urandom, $urandom} | 64'h80;
    if (r == 1) return 64'($urandom_range(128, 255));
    return 64'($urandom_range(0, 127));
  endfunction

  initial begin
    int op;
    reset = 1'b0;
    idleInputs();
    pend = 1'b0; pWe = 1'b0; pAddr = '0; pData = '0; denied = 0;
    expValid = 1'b0; expRdata = '0;

    // Reset held: requests present but nothing may reach memory
    cpu_read = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk1("rst_init_busy", init_busy, 1'b1);
      chk1("rst_cpu_stall", cpu_stall, 1'b1);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
      chk1("rst_dbg_valid", dbg_valid, 1'b0);
      chk("rst_dbg_rdata", dbg_rdata, 64'd0);
    end

    doClear();
    chkMemImage("clear_image");

    // CPU store then load, zero latency
    runCycle(2, 64'd5, 64'hDEAD_BEEF);
    chk1("cpu_wr_stall", obsStall, 1'b0);
    runCycle(1, 64'd5, 64'd0);
    chk("cpu_rd_data", obsCpuRdata, 64'hDEAD_BEEF);
    chk1("cpu_rd_stall", obsStall, 1'b0);

    // Debug read blocked by three CPU reads, then granted
    dbgStart(1'b0, 64'd5, 64'd0);
    for (int k = 0; k < 3; k++) begin
      runCycle(1, 64'd5, 64'd0);
      chk1("dbg_blocked_gnt", obsGnt, 1'b0);
    end
    runCycle(0, 64'd0, 64'd0);
    chk1("dbg_cycle4_gnt", obsGnt, 1'b1);
    runCycle(0, 64'd0, 64'd0);
    chk1("dbg_cycle5_valid", obsValid, 1'b1);
    chk("dbg_cycle5_rdata", obsDbgRdata, 64'hDEAD_BEEF);

    // Out-of-range debug write and read
    dbgStart(1'b1, 64'd200, 64'd1);
    runCycle(0, 64'd0, 64'd0);
    chk1("oor_wr_gnt", obsGnt, 1'b1);
    chk1("oor_wr_mem_write", obsMemWrite, 1'b0);
    dbgStart(1'b0, 64'd200, 64'd0);
    runCycle(0, 64'd0, 64'd0);
    runCycle(0, 64'd0, 64'd0);
    chk1("oor_rd_valid", obsValid, 1'b1);
    chk("oor_rd_rdata", obsDbgRdata, 64'd0);

    // CPU busy every cycle with a debug request held
    dbgStart(1'b0, 64'd7, 64'd0);
    for (int k = 1; k <= 9; k++) begin
      runCycle(2, 64'(k + 20), {$urandom, $urandom});
      chk1("starve_gnt", obsGnt, GUARD && (k == 9));
      chk1("starve_stall", obsStall, GUARD && (k == 9));
    end
    runCycle(0, 64'd0, 64'd0);
    runCycle(0, 64'd0, 64'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (!pend && $urandom_range(0, 3) == 0)
        dbgStart(1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom});
      op = $urandom_range(0, 9);
      op = (op < 4) ? 0 : ((op < 7) ? 1 : 2);
      runCycle(op, randAddr(), {$urandom, $urandom});
    end
    runCycle(0, 64'd0, 64'd0);
    runCycle(0, 64'd0, 64'd0);
    chkMemImage("random_image");

    // Reset arrives during a debug read grant
    dbgStart(1'b0, 64'd5, 64'd0);
    runCycle(0, 64'd0, 64'd0);
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'd5;
    #1;
    chk1("midrst_pre_gnt", dbg_gnt, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk1("midrst_gnt", dbg_gnt, 1'b0);
    chk1("midrst_mem_read", mem_read, 1'b0);
    chk1("midrst_init_busy", init_busy, 1'b1);
    @(negedge clk);
    chk1("midrst_valid", dbg_valid, 1'b0);
    chk("midrst_rdata", dbg_rdata, 64'd0);
    dbg_req = 1'b0;
    doClear();
    runCycle(1, 64'd5, 64'd0);
    chk("after_reclear_rd", obsCpuRdata, 64'd0);
    chkMemImage("reclear_image");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Front-end controller for the single-port 64-bit data memory: on reset it zero-fills every word with a clear sequencer, then shares the memory between the pipeline MEM stage (priority port) and a debug/loader port with a req/gnt handshake. Sits between the MEM stage and the data memory, driving the memory's address, write-data, read and write strobes.

## Interface
- DEPTH, 128: number of 64-bit words in the data memory.
- DATA_W, 64: data width.
- STARVE_LIMIT, 8: consecutive denied debug cycles before a forced grant (guard build only).

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-low: sampled on clk, asserted when 0.
- cpu_addr  in  64  MEM-stage word index.
- cpu_wdata  in  DATA_W  MEM-stage store data.
- cpu_read, cpu_write  in  1  MEM-stage strobes; never both high.
- cpu_rdata  out  DATA_W  load data, combinational.
- cpu_stall  out  1  MEM stage must hold its access and retry.
- dbg_req  in  1  debug request; held until granted.
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req is high.
- dbg_addr, dbg_wdata  in  64 / DATA_W  debug address and data; stable while dbg_req is high.
- dbg_gnt  out  1  one-cycle pulse: access issued this cycle.
- dbg_rdata  out  DATA_W  registered read data.
- dbg_valid  out  1  one-cycle pulse, the cycle after a read grant.
- mem_addr, mem_wdata  out  64 / DATA_W  to data memory.
- mem_read, mem_write  out  1  to data memory.
- mem_rdata  in  DATA_W  combinational read data from memory.
- init_busy  out  1  clear sequence in progress.

## Operation
- FSM states: CLEAR and RUN. Reset (reset=0) forces CLEAR, clr_cnt=0, starve_cnt=0, dbg_valid=0, dbg_rdata=0.
- While reset=0: mem_write=0, mem_read=0, cpu_stall=1, dbg_gnt=0, init_busy=1.
- CLEAR: each cycle drives mem_write=1, mem_addr=clr_cnt, mem_wdata=0; clr_cnt increments. After the write to DEPTH-1 the FSM goes to RUN. cpu_stall=1, dbg_gnt=0 and init_busy=1 throughout.
- RUN, cpu access present (cpu_read|cpu_write): the CPU owns memory. mem_* mirror cpu_*, cpu_rdata=mem_rdata, cpu_stall=0, dbg_gnt=0.
- RUN, no cpu access and dbg_req=1: the debug port owns memory and dbg_gnt=1. If dbg_we=0, dbg_rdata captures mem_rdata and dbg_valid=1 on the next cycle.
- RUN, idle: mem_read=0, mem_write=0, mem_addr=0.
- Range check, applied to both ports: an address ≥ DEPTH suppresses mem_write and returns 0 as read data. The access still completes, so gnt and valid still pulse.
- cpu_rdata=0 whenever the CPU is not the owner.
- Reset mid-operation: a pending dbg_valid is dropped, the clear restarts from word 0, and the debug requester must re-handshake.

## Timing
- Clear takes exactly DEPTH cycles. init_busy falls on the first cycle after the reset release + DEPTH edge.
- CPU access: zero latency, combinational through the block.
- Debug write: completes in the dbg_gnt cycle.
- Debug read: dbg_valid and dbg_rdata arrive one cycle after dbg_gnt.
- Back-to-back debug grants are allowed on consecutive cycles.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - starve_cnt counts cycles in RUN with dbg_req=1 and dbg_gnt=0. It resets to 0 on any grant or when dbg_req=0.
  - When starve_cnt==STARVE_LIMIT, the next cycle is a forced debug grant: the CPU access is not issued (no mem_write), cpu_stall=1, and starve_cnt is cleared.
- Not defined: strict CPU priority, cpu_stall only during CLEAR or reset, and no starve_cnt logic.

## Structure
- Shared package dmem_pkg: DEPTH, DATA_W, state enum {CLEAR, RUN}, owner encoding {OWN_NONE, OWN_CPU, OWN_DBG, OWN_CLR}.
- One sub-module, dmem_clear_seq: clr_cnt counter with done flag. The owner mux and FSM stay in dmem_arbiter.

## Test plan
- Reset for 2 cycles, then release. Required: 128 writes of 0 to addresses 0..127, init_busy high for 128 cycles, cpu_stall=1 throughout, then 0.
- After clear: cpu_write addr 5 data 0xDEAD_BEEF, next cycle cpu_read addr 5. Required: cpu_rdata=0xDEAD_BEEF in the same cycle, cpu_stall=0.
- dbg_req read addr 5 while cpu_read is active for 3 cycles. Required: no dbg_gnt for those 3 cycles, dbg_gnt in cycle 4, dbg_valid with dbg_rdata=0xDEAD_BEEF in cycle 5.
- dbg write addr 200 data 0x1, then read addr 200. Required: no mem_write issued, and dbg_rdata=0.
- Guard build, STARVE_LIMIT=8: CPU accesses every cycle with dbg_req held. Required: dbg_gnt on cycle 9 with cpu_stall=1 that cycle only. Non-guard build, same stimulus: required no grant.
- Reset asserted mid debug read, in the gnt cycle. Required: no dbg_valid, and the clear restarts at address 0.
